generador_patrones: RTL

Serial pattern transmitter: the driving end of the 1-bit serial stream consumed by `reconocedor_patrones`. It loads a parallel pattern word, shifts the active field out MSB-first one bit per clock, optionally repeats it with a programmable idle gap, and signals completion. Its `out` connects directly to the recognizer's `in`, both for on-chip stimulus and for loop-back self-test.

---
 rtl/generador_patrones.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/generador_patrones.sv
// Serial pattern transmitter: shifts the active field of a parallel word out
// MSB-first, optionally repeating it with an idle gap, then pulses done.
// Outputs are registered. Each edge computes the values for the cycle that
// follows it, so the first bit appears at the same edge that accepts start.
module generador_patrones #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 5,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // S_DONE is the cycle that carries the final bit (or, for an empty
  // frame, the silent cycle after start); done becomes visible as it exits.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   data_q, data_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [REP_W-1:0]   frames, frames_n;
  logic [GAP_W-1:0]   gcnt, gcnt_n;
  logic               out_n, valid_n, busy_n, done_n;

  logic [LEN_W-1:0]   len_sat;
  logic [REP_W-1:0]   reps_eff;

  // Bit-emission source: the live inputs on the accepting edge, the latched
  // registers afterwards.
  logic               emit;
  logic [WIDTH-1:0]   cur_data;
  logic [IDX_W-1:0]   cur_idx;
  logic [REP_W-1:0]   cur_frames;
  logic [LEN_W-1:0]   cur_len;
  logic [GAP_W-1:0]   cur_gap;

  // Clamp frame length to the register width and treat zero repeats as one.
  always_comb begin
    len_sat  = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    reps_eff = (reps == '0) ? REP_W'(1) : reps;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    data_n     = data_q;
    len_n      = len_q;
    gap_n      = gap_q;
    idx_n      = idx;
    frames_n   = frames;
    gcnt_n     = gcnt;
    out_n      = 1'b0;
    valid_n    = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    emit       = 1'b0;
    cur_data   = data_q;
    cur_idx    = idx;
    cur_frames = frames;
    cur_len    = len_q;
    cur_gap    = gap_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          data_n   = data;
          len_n    = len_sat;
          gap_n    = gap;
          frames_n = reps_eff;
          if (len_sat == '0) begin
            state_n = S_DONE;
          end else begin
            emit       = 1'b1;
            cur_data   = data;
            cur_idx    = IDX_W'(len_sat - LEN_W'(1));
            cur_frames = reps_eff;
            cur_len    = len_sat;
            cur_gap    = gap;
          end
        end
      end
      S_SHIFT: begin
        emit = 1'b1;
      end
      S_GAP: begin
        busy_n = 1'b1;
        if (gcnt == GAP_W'(1)) begin
          state_n = S_SHIFT;
          idx_n   = IDX_W'(len_q - LEN_W'(1));
        end else begin
          gcnt_n = gcnt - GAP_W'(1);
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (emit) begin
      out_n    = cur_data[cur_idx];
      valid_n  = 1'b1;
      busy_n   = 1'b1;
      frames_n = cur_frames;
      if (cur_idx == '0) begin
        if (cur_frames == REP_W'(1)) begin
          state_n = S_DONE;
        end else begin
          frames_n = cur_frames - REP_W'(1);
          if (cur_gap != '0) begin
            state_n = S_GAP;
            gcnt_n  = cur_gap;
          end else begin
            state_n = S_SHIFT;
            idx_n   = IDX_W'(cur_len - LEN_W'(1));
          end
        end
      end else begin
        state_n = S_SHIFT;
        idx_n   = cur_idx - IDX_W'(1);
      end
    end
  end

  // State, latched request and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      data_q <= '0;
      len_q  <= '0;
      gap_q  <= '0;
      idx    <= '0;
      frames <= '0;
      gcnt   <= '0;
      out    <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      data_q <= data_n;
      len_q  <= len_n;
      gap_q  <= gap_n;
      idx    <= idx_n;
      frames <= frames_n;
      gcnt   <= gcnt_n;
      out    <= out_n;
      valid  <= valid_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule
